// File: rtl/alu_result_display.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_display
// Purpose  : Rebuilds the 8-bit ALU result from nibbles R1/R2 and the Neg
//            flag, converts it to signed-magnitude decimal with a sequential
//            double-dabble engine, and scans it onto a 4-digit active-low
//            seven-segment display.
// Ports    : clk        - system clock, all logic on posedge
//            rst_n      - asynchronous active-low reset
//            R1 / R2    - ALU result high / low nibble
//            Neg        - ALU negative flag
//            student_id - ID digit shown on digit 3 (STUDENT_ID_EN only)
//            seg        - segments {g,f,e,d,c,b,a}, active-low
//            an         - digit enables, active-low, an[0]=ones .. an[3]=sign
//            busy       - high while a conversion is in progress
// Options  : `define STUDENT_ID_EN to show student_id on digit 3 when the
//            converted value is positive.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_display #(
    parameter int SCAN_DIV = 50000,
    parameter int CW       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] R1,
    input  logic [3:0] R2,
    input  logic       Neg,
    input  logic [3:0] student_id,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_SHIFT = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    // Display digit codes: 0..9 are decimal digits, the rest are symbols.
    localparam logic [3:0] c_CODE_MINUS = 4'hA;
    localparam logic [3:0] c_CODE_BLANK = 4'hF;
`ifdef STUDENT_ID_EN
    localparam logic [3:0] c_CODE_ID    = 4'hB;
`endif

    localparam logic [6:0]    c_SEG_MINUS = 7'b0111111;
    localparam logic [6:0]    c_SEG_BLANK = 7'b1111111;
    localparam logic [CW-1:0] c_SCAN_LAST = CW'(SCAN_DIV - 1);

    logic [1:0]    state_q, state_d;
    logic [8:0]    cap_q, last_val_q;
    logic          valid_q;
    logic [19:0]   sh_q;
    logic [2:0]    bcnt_q;
    logic [3:0]    hund_q, tens_q, ones_q, dig3_q;
    logic [CW-1:0] scan_q, scan_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;

    logic [8:0]    w_sample;
    logic          w_new_sample;
    logic [7:0]    w_mag;
    logic [3:0]    w_code;

    assign w_sample     = {Neg, R1, R2};
    assign w_new_sample = !valid_q || (w_sample != last_val_q);
    assign w_mag        = cap_q[8] ? (~cap_q[7:0] + 8'd1) : cap_q[7:0];

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b1000110;
            4'hD:    return 7'b0100001;
            4'hE:    return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [6:0] code_glyph(input logic [3:0] c);
        if (c <= 4'd9)             return hex_glyph(c);
        else if (c == c_CODE_MINUS) return c_SEG_MINUS;
        else                        return c_SEG_BLANK;
    endfunction

    // One double-dabble step: correct every BCD nibble >= 5, then shift.
    function automatic logic [19:0] dd_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int n = 0; n < 3; n++) begin
            if (t[8 + 4*n +: 4] >= 4'd5)
                t[8 + 4*n +: 4] = t[8 + 4*n +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= c_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (w_new_sample) state_d = c_LOAD;
            c_LOAD:  state_d = c_SHIFT;
            c_SHIFT: if (bcnt_q == 3'd7) state_d = c_DONE;
            default: state_d = c_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state_q != c_IDLE);
    end

    // ---------------- Conversion datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q      <= '0;
            last_val_q <= '0;
            valid_q    <= 1'b0;
            sh_q       <= '0;
            bcnt_q     <= '0;
            hund_q     <= c_CODE_BLANK;
            tens_q     <= c_CODE_BLANK;
            ones_q     <= c_CODE_BLANK;
            dig3_q     <= c_CODE_BLANK;
        end else begin
            case (state_q)
                c_IDLE: begin
                    if (w_new_sample) cap_q <= w_sample;
                end
                c_LOAD: begin
                    sh_q   <= {12'b0, w_mag};
                    bcnt_q <= '0;
                end
                c_SHIFT: begin
                    sh_q   <= dd_step(sh_q);
                    bcnt_q <= bcnt_q + 3'd1;
                end
                default: begin
                    // Leading-zero blanking on hundreds and tens only.
                    hund_q <= (sh_q[19:16] == 4'd0) ? c_CODE_BLANK : sh_q[19:16];
                    tens_q <= (sh_q[19:12] == 8'd0) ? c_CODE_BLANK : sh_q[15:12];
                    ones_q <= sh_q[11:8];
`ifdef STUDENT_ID_EN
                    dig3_q <= cap_q[8] ? c_CODE_MINUS : c_CODE_ID;
`else
                    dig3_q <= cap_q[8] ? c_CODE_MINUS : c_CODE_BLANK;
`endif
                    last_val_q <= cap_q;
                    valid_q    <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- Display scan ----------------
    // seg and an are both computed from the next index so they change
    // together on the same edge.
    always_comb begin
        scan_d = scan_q + CW'(1);
        idx_d  = idx_q;
        if (scan_q == c_SCAN_LAST) begin
            scan_d = '0;
            idx_d  = idx_q + 2'd1;
        end
        case (idx_d)
            2'd0:    w_code = ones_q;
            2'd1:    w_code = tens_q;
            2'd2:    w_code = hund_q;
            default: w_code = dig3_q;
        endcase
        seg_d = code_glyph(w_code);
`ifdef STUDENT_ID_EN
        // student_id is sampled live while digit 3 is being driven.
        if (idx_d == 2'd3 && dig3_q == c_CODE_ID) seg_d = hex_glyph(student_id);
`endif
        an_d = ~(4'b0001 << idx_d);
    end

`ifndef STUDENT_ID_EN
    logic w_unused_id;
    assign w_unused_id = ^student_id;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q <= '0;
            idx_q  <= '0;
            seg_q  <= c_SEG_BLANK;
            an_q   <= 4'hF;
        end else begin
            scan_q <= scan_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_display
// Purpose  : Directed self-checking bench for alu_result_display with a short
//            scan period (SCAN_DIV=4) so every digit is visited quickly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_display;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] R1 = 4'h0;
    logic [3:0] R2 = 4'h0;
    logic       Neg = 1'b0;
    logic [3:0] student_id = 4'h0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] GM = 7'b0111111;
    localparam logic [6:0] GB = 7'b1111111;
    localparam logic [6:0] GHB = 7'b0000011;

    localparam logic [3:0] AN_ONES = 4'b1110;
    localparam logic [3:0] AN_TENS = 4'b1101;
    localparam logic [3:0] AN_HUND = 4'b1011;
    localparam logic [3:0] AN_SIGN = 4'b0111;

    alu_result_display #(.SCAN_DIV(4), .CW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .R1         (R1),
        .R2         (R2),
        .Neg        (Neg),
        .student_id (student_id),
        .seg        (seg),
        .an         (an),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Waits (bounded) until the requested digit is enabled and returns its segments.
    task automatic get_digit(input logic [3:0] which, output logic [6:0] s, output bit ok);
        ok = 1'b0;
        s  = 7'bx;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (an === which) begin
                s  = seg;
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Waits (bounded) for a conversion to start and finish, then lets the scan settle.
    task automatic wait_conv(output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (busy !== 1'b1) return;
        n = 0;
        while (busy !== 1'b0 && n < 30) begin @(negedge clk); n++; end
        if (busy !== 1'b0) return;
        repeat (3) @(negedge clk);
        ok = 1'b1;
    endtask

    task automatic test_reset;
        logic [6:0] s;
        bit ok;
        int hi;
        rst_n = 1'b0; R1 = 4'h0; R2 = 4'h0; Neg = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (seg !== GB)   begin n_fail++; $display("FAIL reset_seg: got %b want %b", seg, GB); end
        n_cmp++; if (an !== 4'hF)  begin n_fail++; $display("FAIL reset_an: got %b want 1111", an); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy === 1'b1) hi++;
        end
        n_cmp++; if (hi != 10) begin n_fail++; $display("FAIL reset_busy_len: got %0d want 10", hi); end
        get_digit(AN_ONES, s, ok);
        n_cmp++; if (!ok || s !== G0) begin n_fail++; $display("FAIL zero_ones: got %b want %b", s, G0); end
        get_digit(AN_TENS, s, ok);
        n_cmp++; if (!ok || s !== GB) begin n_fail++; $display("FAIL zero_tens: got %b want %b", s, GB); end
        get_digit(AN_HUND, s, ok);
        n_cmp++; if (!ok || s !== GB) begin n_fail++; $display("FAIL zero_hund: got %b want %b", s, GB); end
        get_digit(AN_SIGN, s, ok);
        n_cmp++; if (!ok || s !== GB) begin n_fail++; $display("FAIL zero_sign: got %b want %b", s, GB); end
    endtask

    task automatic test_max_positive;
        logic [6:0] s;
        bit ok;
        R1 = 4'hF; R2 = 4'hF; Neg = 1'b0;
        wait_conv(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL p255_conv: got timeout want done"); end
        get_digit(AN_HUND, s, ok);
        n_cmp++; if (!ok || s !== G2) begin n_fail++; $display("FAIL p255_hund: got %b want %b", s, G2); end
        get_digit(AN_TENS, s, ok);
        n_cmp++; if (!ok || s !== G5) begin n_fail++; $display("FAIL p255_tens: got %b want %b", s, G5); end
        get_digit(AN_ONES, s, ok);
        n_cmp++; if (!ok || s !== G5) begin n_fail++; $display("FAIL p255_ones: got %b want %b", s, G5); end
        get_digit(AN_SIGN, s, ok);
        n_cmp++; if (!ok || s !== GB) begin n_fail++; $display("FAIL p255_sign: got %b want %b", s, GB); end
    endtask

    task automatic test_negative;
        logic [6:0] s;
        bit ok;
        R1 = 4'hF; R2 = 4'hD; Neg = 1'b1;
        wait_conv(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL neg3_conv: got timeout want done"); end
        get_digit(AN_ONES, s, ok);
        n_cmp++; if (!ok || s !== G3) begin n_fail++; $display("FAIL neg3_ones: got %b want %b", s, G3); end
        get_digit(AN_SIGN, s, ok);
        n_cmp++; if (!ok || s !== GM) begin n_fail++; $display("FAIL neg3_sign: got %b want %b", s, GM); end
        get_digit(AN_TENS, s, ok);
        n_cmp++; if (!ok || s !== GB) begin n_fail++; $display("FAIL neg3_tens: got %b want %b", s, GB); end
        get_digit(AN_HUND, s, ok);
        n_cmp++; if (!ok || s !== GB) begin n_fail++; $display("FAIL neg3_hund: got %b want %b", s, GB); end
    endtask

    task automatic test_negative_zero;
        logic [6:0] s;
        bit ok;
        R1 = 4'h0; R2 = 4'h0; Neg = 1'b1;
        wait_conv(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL negzero_conv: got timeout want done"); end
        get_digit(AN_ONES, s, ok);
        n_cmp++; if (!ok || s !== G0) begin n_fail++; $display("FAIL negzero_ones: got %b want %b", s, G0); end
        get_digit(AN_SIGN, s, ok);
        n_cmp++; if (!ok || s !== GM) begin n_fail++; $display("FAIL negzero_sign: got %b want %b", s, GM); end
    endtask

    task automatic test_back_to_back;
        logic [6:0] s;
        bit ok;
        int n, gap;
        R1 = 4'h0; R2 = 4'hA; Neg = 1'b0;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);          // now two cycles into SHIFT
        R1 = 4'h6; R2 = 4'h4;
        n = 0;
        while (busy === 1'b1 && n < 40) begin @(negedge clk); n++; end
        gap = 0;
        while (busy === 1'b0 && gap < 5) begin @(negedge clk); gap++; n++; end
        n_cmp++; if (gap != 1) begin n_fail++; $display("FAIL b2b_gap: got %0d want 1", gap); end
        while (busy === 1'b1 && n < 60) begin @(negedge clk); n++; end
        n_cmp++; if (n > 20) begin n_fail++; $display("FAIL b2b_latency: got %0d want <=20", n); end
        repeat (3) @(negedge clk);
        get_digit(AN_HUND, s, ok);
        n_cmp++; if (!ok || s !== G1) begin n_fail++; $display("FAIL b2b_hund: got %b want %b", s, G1); end
        get_digit(AN_TENS, s, ok);
        n_cmp++; if (!ok || s !== G0) begin n_fail++; $display("FAIL b2b_tens: got %b want %b", s, G0); end
        get_digit(AN_ONES, s, ok);
        n_cmp++; if (!ok || s !== G0) begin n_fail++; $display("FAIL b2b_ones: got %b want %b", s, G0); end
    endtask

    task automatic test_reset_mid;
        logic [6:0] s;
        bit ok;
        int n;
        R1 = 4'h2; R2 = 4'hA; Neg = 1'b0;   // 42
        n = 0;
        while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (seg !== GB)    begin n_fail++; $display("FAIL midrst_seg: got %b want %b", seg, GB); end
        n_cmp++; if (an !== 4'hF)   begin n_fail++; $display("FAIL midrst_an: got %b want 1111", an); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_conv(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL midrst_conv: got timeout want done"); end
        get_digit(AN_ONES, s, ok);
        n_cmp++; if (!ok || s !== G2) begin n_fail++; $display("FAIL midrst_ones: got %b want %b", s, G2); end
        get_digit(AN_TENS, s, ok);
        n_cmp++; if (!ok || s !== G4) begin n_fail++; $display("FAIL midrst_tens: got %b want %b", s, G4); end
    endtask

    task automatic test_student_id;
        logic [6:0] s;
        logic [6:0] exp_pos;
        bit ok;
`ifdef STUDENT_ID_EN
        exp_pos = GHB;
`else
        exp_pos = GB;
`endif
        student_id = 4'hB; R1 = 4'h0; R2 = 4'h7; Neg = 1'b0;
        wait_conv(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL sid_conv: got timeout want done"); end
        get_digit(AN_SIGN, s, ok);
        n_cmp++; if (!ok || s !== exp_pos) begin n_fail++; $display("FAIL sid_pos_sign: got %b want %b", s, exp_pos); end
        Neg = 1'b1;                          // mag = 0xF9 = 249
        wait_conv(ok);
        get_digit(AN_SIGN, s, ok);
        n_cmp++; if (!ok || s !== GM) begin n_fail++; $display("FAIL sid_neg_sign: got %b want %b", s, GM); end
        get_digit(AN_ONES, s, ok);
        n_cmp++; if (!ok || s !== G9) begin n_fail++; $display("FAIL sid_neg_ones: got %b want %b", s, G9); end
    endtask

    initial begin
        test_reset;
        test_max_positive;
        test_negative;
        test_negative_zero;
        test_back_to_back;
        test_reset_mid;
        test_student_id;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
